// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the parametrised memory.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } mem_state_t;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

endpackage
`default_nettype wire

// File: rtl/mem_clear_seq.sv
`default_nettype none
// ============================================================================
// Module      : mem_clear_seq
// Description : Walks a pointer across every word after reset or on request,
//               asserting busy and driving the zeroing write port.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_clear_seq
    import mem_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int AWIDTH = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    output logic              busy,
    output logic              clr_we,
    output logic [AWIDTH-1:0] clr_addr
);

    localparam logic [AWIDTH-1:0] c_last = AWIDTH'(DEPTH - 1);

    mem_state_t        r_state;
    logic [AWIDTH-1:0] r_ptr;
    logic              r_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    // A fresh request restarts the sweep so every word is hit again
                    if (clr) begin
                        r_ptr <= '0;
                    end else if (r_ptr == c_last) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + AWIDTH'(1);
                    end
                end
                ST_READY: begin
                    if (clr) begin
                        r_state <= ST_CLEAR;
                        r_ptr   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_CLEAR;
                    r_ptr   <= '0;
                    r_busy  <= 1'b1;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign clr_we   = (r_state == ST_CLEAR);
    assign clr_addr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/param_memory.sv
`default_nettype none
// ============================================================================
// Module      : param_memory
// Description : DEPTH x DWIDTH RAM with byte-enabled write, registered read,
//               self-clearing sequencer and selectable read-during-write.
// Revision    : 1.0 - initial release
// ============================================================================
module param_memory
    import mem_pkg::*;
#(
    parameter int DWIDTH   = 16,
    parameter int DEPTH    = 8,
    parameter int AWIDTH   = $clog2(DEPTH),
    parameter int RDW_MODE = RDW_READ_FIRST
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                we,
    input  logic [DWIDTH/8-1:0] be,
    input  logic [AWIDTH-1:0]   waddr,
    input  logic [DWIDTH-1:0]   din,
    input  logic                re,
    input  logic [AWIDTH-1:0]   raddr,
    output logic [DWIDTH-1:0]   dout,
    output logic                rvalid,
    output logic                busy
);

    localparam int              c_nbytes = DWIDTH / 8;
    localparam logic [AWIDTH:0] c_depth  = (AWIDTH + 1)'(DEPTH);

    if ((DWIDTH % 8) != 0) begin : g_bad_dwidth
        $error("param_memory: DWIDTH (%0d) must be a multiple of 8", DWIDTH);
    end
    if (DEPTH < 2) begin : g_bad_depth
        $error("param_memory: DEPTH (%0d) must be at least 2", DEPTH);
    end

    logic [DWIDTH-1:0] r_mem [DEPTH];
    logic [DWIDTH-1:0] r_dout;
    logic              r_rvalid;

    logic              w_busy;
    logic              w_clr_we;
    logic [AWIDTH-1:0] w_clr_addr;
    logic              w_waddr_ok;
    logic              w_raddr_ok;
    logic              w_user_we;
    logic [DWIDTH-1:0] w_merged;
    logic [DWIDTH-1:0] w_rdata;

    mem_clear_seq #(
        .DEPTH  (DEPTH),
        .AWIDTH (AWIDTH)
    ) u_clear_seq (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .busy     (w_busy),
        .clr_we   (w_clr_we),
        .clr_addr (w_clr_addr)
    );

    assign w_waddr_ok = ({1'b0, waddr} < c_depth);
    assign w_raddr_ok = ({1'b0, raddr} < c_depth);
    assign w_user_we  = we && !w_busy && w_waddr_ok;

    for (genvar i = 0; i < c_nbytes; i++) begin : g_byte
        assign w_merged[8*i +: 8] = be[i] ? din[8*i +: 8] : r_mem[waddr][8*i +: 8];
    end

    // The sequencer owns the write port whenever it is sweeping
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_user_we) begin
            r_mem[waddr] <= w_merged;
        end
    end

    always_comb begin
        w_rdata = '0;
        if (w_raddr_ok) begin
            if ((RDW_MODE == RDW_WRITE_FIRST) && w_user_we && (waddr == raddr)) begin
                w_rdata = w_merged;
            end else begin
                w_rdata = r_mem[raddr];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dout   <= '0;
            r_rvalid <= 1'b0;
        end else if (w_busy || !re) begin
            r_rvalid <= 1'b0;
        end else begin
            r_dout   <= w_rdata;
            r_rvalid <= 1'b1;
        end
    end

    assign dout   = r_dout;
    assign rvalid = r_rvalid;
    assign busy   = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_param_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_memory
// Description : Directed bench for param_memory (read-first, write-first and
//               DEPTH=6 instances sharing one stimulus stream).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic        clr;
    logic        we;
    logic [1:0]  be;
    logic [2:0]  waddr;
    logic [15:0] din;
    logic        re;
    logic [2:0]  raddr;

    logic [15:0] dout0, dout1, dout6;
    logic        rvalid0, rvalid1, rvalid6;
    logic        busy0, busy1, busy6;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    param_memory #(.DWIDTH(16), .DEPTH(8), .RDW_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .clr(clr), .we(we), .be(be), .waddr(waddr),
        .din(din), .re(re), .raddr(raddr), .dout(dout0), .rvalid(rvalid0), .busy(busy0)
    );

    param_memory #(.DWIDTH(16), .DEPTH(8), .RDW_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .clr(clr), .we(we), .be(be), .waddr(waddr),
        .din(din), .re(re), .raddr(raddr), .dout(dout1), .rvalid(rvalid1), .busy(busy1)
    );

    param_memory #(.DWIDTH(16), .DEPTH(6), .RDW_MODE(0)) dut6 (
        .clk(clk), .reset(reset), .clr(clr), .we(we), .be(be), .waddr(waddr),
        .din(din), .re(re), .raddr(raddr), .dout(dout6), .rvalid(rvalid6), .busy(busy6)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] b);
        we = 1'b1; waddr = a; din = d; be = b;
        cyc();
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a);
        re = 1'b1; raddr = a;
        cyc();
        re = 1'b0;
    endtask

    // Counts busy samples for both depths; optionally pokes writes/reads while busy
    task automatic measure_busy(input int exp8, input int exp6, input string tag, input bit poke);
        int n0 = 0;
        int n6 = 0;
        int bad = 0;
        for (int i = 0; i < 14; i++) begin
            if (busy0) n0++;
            if (busy6) n6++;
            if (busy0 && rvalid0) bad++;
            if (poke && i == 0) begin
                we = 1'b1; waddr = 3'd0; din = 16'hFFFF; be = 2'b11;
                re = 1'b1; raddr = 3'd0;
            end
            if (poke && i == 3) begin
                we = 1'b0; re = 1'b0;
            end
            cyc();
        end
        chk({tag, "_busy8"}, n0, exp8);
        chk({tag, "_busy6"}, n6, exp6);
        chk({tag, "_rvalid_busy"}, bad, 0);
        chk({tag, "_ready"}, busy0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0;
        be = 2'b00; waddr = '0; raddr = '0; din = '0;
        repeat (2) cyc();
        chk("rst_busy", busy0, 1'b1);
        chk("rst_rvalid", rvalid0, 1'b0);
        chk("rst_dout", dout0, 16'h0000);

        reset = 1'b0;
        measure_busy(8, 6, "rel", 1'b0);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            chk($sformatf("init_d0_%0d", a), dout0, 16'h0000);
            chk($sformatf("init_v0_%0d", a), rvalid0, 1'b1);
            chk($sformatf("init_d6_%0d", a), dout6, 16'h0000);
        end

        wr(3'd3, 16'hA5A5, 2'b11);
        rd(3'd3);
        chk("full_wr_d0", dout0, 16'hA5A5);
        chk("full_wr_d1", dout1, 16'hA5A5);
        wr(3'd3, 16'h1234, 2'b01);
        rd(3'd3);
        chk("be01_d0", dout0, 16'hA534);
        chk("be01_d6", dout6, 16'hA534);
        cyc();
        chk("idle_rvalid", rvalid0, 1'b0);
        chk("idle_hold", dout0, 16'hA534);
        wr(3'd3, 16'hFFFF, 2'b00);
        rd(3'd3);
        chk("be00_noop", dout0, 16'hA534);

        we = 1'b1; waddr = 3'd5; din = 16'hBEEF; be = 2'b11;
        re = 1'b1; raddr = 3'd5;
        cyc();
        we = 1'b0; re = 1'b0;
        chk("rdw_rf", dout0, 16'h0000);
        chk("rdw_wf", dout1, 16'hBEEF);
        chk("rdw_wf_v", rvalid1, 1'b1);
        rd(3'd5);
        chk("rdw_rf_after", dout0, 16'hBEEF);

        we = 1'b1; waddr = 3'd5; din = 16'h0012; be = 2'b01;
        re = 1'b1; raddr = 3'd5;
        cyc();
        we = 1'b0; re = 1'b0;
        chk("rdw_merge_rf", dout0, 16'hBEEF);
        chk("rdw_merge_wf", dout1, 16'hBE12);

        we = 1'b1; waddr = 3'd2; din = 16'h2222; be = 2'b11;
        re = 1'b1; raddr = 3'd3;
        cyc();
        we = 1'b0; re = 1'b0;
        chk("diff_rf", dout0, 16'hA534);
        chk("diff_wf", dout1, 16'hA534);

        for (int a = 0; a < 8; a++) wr(3'(a), 16'h1111, 2'b11);
        rd(3'd7);
        chk("fill_d0", dout0, 16'h1111);
        rd(3'd4);
        chk("fill_d6", dout6, 16'h1111);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        measure_busy(8, 6, "clr", 1'b1);
        chk("clr_dout_hold", dout0, 16'h1111);
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            chk($sformatf("clr_d0_%0d", a), dout0, 16'h0000);
            if (a < 6) chk($sformatf("clr_d6_%0d", a), dout6, 16'h0000);
        end

        clr = 1'b1;
        cyc();
        clr = 1'b0;
        cyc();
        cyc();
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        measure_busy(8, 6, "reclr", 1'b0);

        wr(3'd1, 16'h9999, 2'b11);
        re = 1'b1; raddr = 3'd1;
        cyc();
        re = 1'b0;
        chk("pend_d0", dout0, 16'h9999);
        chk("pend_v0", rvalid0, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("async_dout", dout0, 16'h0000);
        chk("async_rvalid", rvalid0, 1'b0);
        chk("async_busy", busy0, 1'b1);
        cyc();
        reset = 1'b0;
        measure_busy(8, 6, "rst1", 1'b0);

        clr = 1'b1;
        cyc();
        clr = 1'b0;
        repeat (4) cyc();
        #2 reset = 1'b1;
        #1;
        chk("midclr_busy", busy0, 1'b1);
        cyc();
        reset = 1'b0;
        measure_busy(8, 6, "rst2", 1'b0);
        rd(3'd1);
        chk("rst_cleared", dout0, 16'h0000);

        wr(3'd5, 16'h5555, 2'b11);
        wr(3'd6, 16'h6666, 2'b11);
        wr(3'd7, 16'h7777, 2'b11);
        rd(3'd7);
        chk("oor7_d6", dout6, 16'h0000);
        chk("oor7_v6", rvalid6, 1'b1);
        chk("oor7_d0", dout0, 16'h7777);
        rd(3'd6);
        chk("oor6_d6", dout6, 16'h0000);
        rd(3'd5);
        chk("d6_addr5", dout6, 16'h5555);
        for (int a = 0; a < 5; a++) begin
            rd(3'(a));
            chk($sformatf("d6_keep_%0d", a), dout6, 16'h0000);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
